// File: rtl/instruction_fetch.sv
// Instruction fetch: pc register driving a combinational imem, feeding a small
// FIFO toward decode. Redirects flush the buffer and restart fetch at the target.

module fetch_entry (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [63:0] din,
  output logic [63:0] dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  dout <= '0;
    else if (we) dout <= din;
  end

endmodule

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misaligned
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  logic [31:0]             pc;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    push, pop;
  logic [DEPTH-1:0]        wen;
  logic [DEPTH-1:0][63:0]  ent_q;
  fetch_entry_t            wr_ent, head;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts a fetch when the head leaves the same edge.
  assign push      = !redirect_valid && ((count < DEPTH_C) || pop);

  assign wr_ent.pc    = pc;
  assign wr_ent.instr = imem_instr;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign wen[g] = push && (wr_ptr == PTR_W'(g));
    fetch_entry u_ent (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (wen[g]),
      .din  (wr_ent),
      .dout (ent_q[g])
    );
  end

  assign head      = ent_q[rd_ptr];
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;

  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      misaligned <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= {redirect_pc[31:2], 2'b00};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      if (redirect_pc[1:0] != 2'b00) misaligned <= 1'b1;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
